// File: rtl/mii_pkg.sv
// Shared types and constants for the MII (MAC side) to RMII (PHY side) bridge.
package mii_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_ALIGN,
    RX_DATA
  } rx_state_e;

  localparam logic [1:0] DIBIT_PRE = 2'b01;
  localparam logic [1:0] DIBIT_FC  = 2'b10;
  localparam logic [3:0] NIBBLE_FC = 4'hE;

  // Selects the dibit of a nibble for slot 0 (low pair) or slot 1 (high pair).
  function automatic logic [1:0] nibble_dibit(input logic [3:0] nib, input logic hi);
    return hi ? nib[3:2] : nib[1:0];
  endfunction

endpackage

// File: rtl/rmii_rx_align.sv
// RMII receive aligner: dibit-to-nibble assembly anchored on the 01 dibit,
// a one-nibble skid register, and MII-side outputs updated on mii_clk_en.
module rmii_rx_align
  import mii_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_en,
  input  logic       clk_en,
  input  logic [1:0] rmii_rxd,
  input  logic       rmii_crs_dv,
  input  logic       rmii_rx_er,
  output logic [3:0] mii_rxd,
  output logic       mii_rx_dv,
  output logic       mii_rx_er,
  output logic       mii_crs
);

  rx_state_e  state_q, state_d;
  logic       half_q, half_d;
  logic [1:0] lo_q, lo_d;
  logic       lo_er_q, lo_er_d;
  logic       lo_crs_q, lo_crs_d;
  logic       crs_q, crs_d;
  logic       fc_q, fc_d;
  logic       skid_vld_q, skid_vld_d;
  logic [3:0] skid_nib_q, skid_nib_d;
  logic       skid_er_q, skid_er_d;
  logic       skid_crs_q, skid_crs_d;
  logic [3:0] mii_rxd_q, mii_rxd_d;
  logic       mii_rx_dv_q, mii_rx_dv_d;
  logic       mii_rx_er_q, mii_rx_er_d;
  logic       mii_crs_q, mii_crs_d;

  logic       nib_done;
  logic [3:0] nib_val;
  logic       nib_er;
  logic       nib_crs;

  always_comb begin
    state_d  = state_q;
    half_d   = half_q;
    lo_d     = lo_q;
    lo_er_d  = lo_er_q;
    lo_crs_d = lo_crs_q;
    crs_d    = crs_q;
    fc_d     = fc_q;
    nib_done = 1'b0;
    nib_val  = '0;
    nib_er   = 1'b0;
    nib_crs  = 1'b0;

    if (sample_en) begin
      unique case (state_q)
        RX_IDLE: begin
          half_d = 1'b0;
          fc_d   = 1'b0;
          if (rmii_crs_dv) begin
            state_d = RX_ALIGN;
            crs_d   = 1'b1;
            fc_d    = rmii_rx_er && (rmii_rxd == DIBIT_FC);
          end
        end
        RX_ALIGN: begin
          // A false carrier parks here, never aligning, until crs_dv drops.
          if (!rmii_crs_dv) begin
            state_d = RX_IDLE;
            crs_d   = 1'b0;
            fc_d    = 1'b0;
          end else if (!fc_q && rmii_rxd == DIBIT_PRE) begin
            state_d  = RX_DATA;
            half_d   = 1'b1;
            lo_d     = rmii_rxd;
            lo_er_d  = 1'b0;
            lo_crs_d = 1'b1;
          end
        end
        RX_DATA: begin
          if (!half_q) begin
            half_d   = 1'b1;
            lo_d     = rmii_rxd;
            lo_er_d  = rmii_rx_er;
            lo_crs_d = rmii_crs_dv;
            if (!rmii_crs_dv) crs_d = 1'b0;
          end else begin
            half_d = 1'b0;
            // crs_dv low on both dibits marks end of frame; the pair is not data.
            if (!lo_crs_q && !rmii_crs_dv) begin
              state_d = RX_IDLE;
              crs_d   = 1'b0;
            end else begin
              nib_done = 1'b1;
              nib_val  = {rmii_rxd, lo_q};
              nib_er   = lo_er_q | rmii_rx_er;
              nib_crs  = crs_q;
            end
          end
        end
        default: state_d = RX_IDLE;
      endcase
    end
  end

  always_comb begin
    skid_vld_d  = clk_en ? 1'b0 : skid_vld_q;
    skid_nib_d  = skid_nib_q;
    skid_er_d   = skid_er_q;
    skid_crs_d  = skid_crs_q;
    mii_rxd_d   = mii_rxd_q;
    mii_rx_dv_d = mii_rx_dv_q;
    mii_rx_er_d = mii_rx_er_q;
    mii_crs_d   = mii_crs_q;

    if (nib_done) begin
      skid_vld_d = 1'b1;
      skid_nib_d = nib_val;
      skid_er_d  = nib_er;
      skid_crs_d = nib_crs;
    end

    if (clk_en) begin
      if (skid_vld_q) begin
        mii_rxd_d   = skid_nib_q;
        mii_rx_dv_d = 1'b1;
        mii_rx_er_d = skid_er_q;
        mii_crs_d   = skid_crs_q;
      end else if (fc_q) begin
        mii_rxd_d   = NIBBLE_FC;
        mii_rx_dv_d = 1'b0;
        mii_rx_er_d = 1'b1;
        mii_crs_d   = 1'b1;
      end else begin
        mii_rxd_d   = '0;
        mii_rx_dv_d = 1'b0;
        mii_rx_er_d = 1'b0;
        mii_crs_d   = crs_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RX_IDLE;
      half_q      <= 1'b0;
      lo_q        <= '0;
      lo_er_q     <= 1'b0;
      lo_crs_q    <= 1'b0;
      crs_q       <= 1'b0;
      fc_q        <= 1'b0;
      skid_vld_q  <= 1'b0;
      skid_nib_q  <= '0;
      skid_er_q   <= 1'b0;
      skid_crs_q  <= 1'b0;
      mii_rxd_q   <= '0;
      mii_rx_dv_q <= 1'b0;
      mii_rx_er_q <= 1'b0;
      mii_crs_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      half_q      <= half_d;
      lo_q        <= lo_d;
      lo_er_q     <= lo_er_d;
      lo_crs_q    <= lo_crs_d;
      crs_q       <= crs_d;
      fc_q        <= fc_d;
      skid_vld_q  <= skid_vld_d;
      skid_nib_q  <= skid_nib_d;
      skid_er_q   <= skid_er_d;
      skid_crs_q  <= skid_crs_d;
      mii_rxd_q   <= mii_rxd_d;
      mii_rx_dv_q <= mii_rx_dv_d;
      mii_rx_er_q <= mii_rx_er_d;
      mii_crs_q   <= mii_crs_d;
    end
  end

  assign mii_rxd   = mii_rxd_q;
  assign mii_rx_dv = mii_rx_dv_q;
  assign mii_rx_er = mii_rx_er_q;
  assign mii_crs   = mii_crs_q;

endmodule

// File: rtl/mii_rmii.sv
// MII MAC to RMII PHY bridge on the 50 MHz reference clock: phase counter,
// mii_clk_en strobe and TX nibble splitting here; RX assembly in rmii_rx_align.
module mii_rmii
  import mii_pkg::*;
#(
  parameter int unsigned DIV10     = 10,
  parameter int unsigned SAMPLE_PT = 5
) (
  input  logic       rmii_refclk,
  input  logic       rst,
  input  logic       speed_100,
  output logic       mii_clk_en,
  input  logic [3:0] mii_txd,
  input  logic       mii_tx_en,
  input  logic       mii_tx_er,
  output logic [3:0] mii_rxd,
  output logic       mii_rx_dv,
  output logic       mii_rx_er,
  output logic       mii_crs,
  output logic [1:0] rmii_txd,
  output logic       rmii_tx_en,
  input  logic [1:0] rmii_rxd,
  input  logic       rmii_crs_dv,
  input  logic       rmii_rx_er,
  output logic       tx_er_seen
);

  localparam int unsigned PW = (DIV10 > 1) ? $clog2(2 * DIV10) : 1;
  typedef logic [PW-1:0] phase_t;

  localparam phase_t LAST_100 = phase_t'(1);
  localparam phase_t LAST_10  = phase_t'(2 * DIV10 - 1);
  localparam phase_t DIV_P    = phase_t'(DIV10);
  localparam phase_t SP_LO    = phase_t'(SAMPLE_PT);
  localparam phase_t SP_HI    = phase_t'(DIV10 + SAMPLE_PT);

  phase_t     phase_q, phase_d;
  logic       speed_q, speed_d;
  logic [3:0] tx_nib_q, tx_nib_d;
  logic [1:0] rmii_txd_q, rmii_txd_d;
  logic       rmii_tx_en_q, rmii_tx_en_d;
  logic       tx_er_seen_q, tx_er_seen_d;

  logic       clk_en;
  logic       sample_en;
  logic       slot_d;
  phase_t     last;

  // The strobe decodes from the registered speed, so a speed change only
  // restarts the counter and cannot create a spurious mii_clk_en pulse.
  always_comb begin
    last      = speed_q ? LAST_100 : LAST_10;
    clk_en    = (phase_q == last);
    sample_en = speed_q ? 1'b1 : ((phase_q == SP_LO) || (phase_q == SP_HI));
    speed_d   = speed_100;

    if (speed_100 != speed_q) begin
      phase_d = '0;
    end else if (clk_en) begin
      phase_d = '0;
    end else begin
      phase_d = phase_q + phase_t'(1);
    end
  end

  // RMII TX outputs are registered one cycle ahead of the slot they drive.
  always_comb begin
    slot_d       = speed_d ? phase_d[0] : (phase_d >= DIV_P);
    tx_nib_d     = clk_en ? (mii_tx_en ? mii_txd : 4'h0) : tx_nib_q;
    rmii_txd_d   = nibble_dibit(tx_nib_d, slot_d);
    rmii_tx_en_d = clk_en ? mii_tx_en : rmii_tx_en_q;
    tx_er_seen_d = tx_er_seen_q | (clk_en & mii_tx_en & mii_tx_er);
  end

  always_ff @(posedge rmii_refclk or posedge rst) begin
    if (rst) begin
      phase_q      <= '0;
      speed_q      <= 1'b1;
      tx_nib_q     <= '0;
      rmii_txd_q   <= '0;
      rmii_tx_en_q <= 1'b0;
      tx_er_seen_q <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      speed_q      <= speed_d;
      tx_nib_q     <= tx_nib_d;
      rmii_txd_q   <= rmii_txd_d;
      rmii_tx_en_q <= rmii_tx_en_d;
      tx_er_seen_q <= tx_er_seen_d;
    end
  end

  rmii_rx_align u_rx (
    .clk         (rmii_refclk),
    .rst         (rst),
    .sample_en   (sample_en),
    .clk_en      (clk_en),
    .rmii_rxd    (rmii_rxd),
    .rmii_crs_dv (rmii_crs_dv),
    .rmii_rx_er  (rmii_rx_er),
    .mii_rxd     (mii_rxd),
    .mii_rx_dv   (mii_rx_dv),
    .mii_rx_er   (mii_rx_er),
    .mii_crs     (mii_crs)
  );

  assign mii_clk_en = clk_en;
  assign rmii_txd   = rmii_txd_q;
  assign rmii_tx_en = rmii_tx_en_q;
  assign tx_er_seen = tx_er_seen_q;

endmodule

// File: tb/tb_mii_rmii.sv
// Directed bench for mii_rmii: TX splitting, RX assembly, end-of-frame toggle,
// false carrier, 10 Mb/s timing and asynchronous reset mid-frame.
module tb_mii_rmii;

  logic       rmii_refclk = 1'b0;
  logic       rst;
  logic       speed_100;
  logic       mii_clk_en;
  logic [3:0] mii_txd;
  logic       mii_tx_en;
  logic       mii_tx_er;
  logic [3:0] mii_rxd;
  logic       mii_rx_dv;
  logic       mii_rx_er;
  logic       mii_crs;
  logic [1:0] rmii_txd;
  logic       rmii_tx_en;
  logic [1:0] rmii_rxd;
  logic       rmii_crs_dv;
  logic       rmii_rx_er;
  logic       tx_er_seen;

  int unsigned total  = 0;
  int unsigned passed = 0;

  logic [1:0]  st_d [64];
  logic        st_c [64];
  logic        st_e [64];
  int unsigned st_n;
  logic [3:0]  cap_nib [$];
  logic        cap_er  [$];
  logic        cap_crs [$];

  always #10 rmii_refclk = ~rmii_refclk;

  mii_rmii #(.DIV10(10), .SAMPLE_PT(5)) dut (
    .rmii_refclk (rmii_refclk),
    .rst         (rst),
    .speed_100   (speed_100),
    .mii_clk_en  (mii_clk_en),
    .mii_txd     (mii_txd),
    .mii_tx_en   (mii_tx_en),
    .mii_tx_er   (mii_tx_er),
    .mii_rxd     (mii_rxd),
    .mii_rx_dv   (mii_rx_dv),
    .mii_rx_er   (mii_rx_er),
    .mii_crs     (mii_crs),
    .rmii_txd    (rmii_txd),
    .rmii_tx_en  (rmii_tx_en),
    .rmii_rxd    (rmii_rxd),
    .rmii_crs_dv (rmii_crs_dv),
    .rmii_rx_er  (rmii_rx_er),
    .tx_er_seen  (tx_er_seen)
  );

  task automatic step();
    @(posedge rmii_refclk);
    #1;
  endtask

  // Leaves the bench at a point where the next clock edge is a strobe edge.
  task automatic wait_strobe();
    for (int i = 0; i < 64 && !mii_clk_en; i++) step();
    if (!mii_clk_en) begin
      total++;
      $display("FAIL strobe_timeout mii_clk_en=%b expected 1", mii_clk_en);
    end
  endtask

  task automatic add(input logic [1:0] d, input logic c, input logic e);
    st_d[st_n] = d;
    st_c[st_n] = c;
    st_e[st_n] = e;
    st_n++;
  endtask

  // Drives the queued dibits (each held 'hold' cycles) plus idle, recording valid MII nibbles.
  task automatic drive_rx(input int unsigned hold);
    logic prev;
    cap_nib.delete();
    cap_er.delete();
    cap_crs.delete();
    for (int unsigned i = 0; i < st_n + 8; i++) begin
      if (i < st_n) begin
        rmii_rxd = st_d[i]; rmii_crs_dv = st_c[i]; rmii_rx_er = st_e[i];
      end else begin
        rmii_rxd = 2'b00; rmii_crs_dv = 1'b0; rmii_rx_er = 1'b0;
      end
      for (int unsigned k = 0; k < hold; k++) begin
        prev = mii_clk_en;
        step();
        if (prev && mii_rx_dv) begin
          cap_nib.push_back(mii_rxd);
          cap_er.push_back(mii_rx_er);
          cap_crs.push_back(mii_crs);
        end
      end
    end
  endtask

  task automatic load_basic_frame();
    st_n = 0;
    add(2'b00, 1, 0); add(2'b00, 1, 0); add(2'b01, 1, 0); add(2'b01, 1, 0);
    add(2'b01, 1, 0); add(2'b11, 1, 0); add(2'b10, 1, 0); add(2'b10, 1, 0);
  endtask

  task automatic test_reset();
    rst = 1'b1; speed_100 = 1'b1;
    mii_txd = '0; mii_tx_en = 1'b0; mii_tx_er = 1'b0;
    rmii_rxd = '0; rmii_crs_dv = 1'b0; rmii_rx_er = 1'b0;
    repeat (3) step();
    total++;
    if ({mii_clk_en, mii_rxd, mii_rx_dv, mii_rx_er, mii_crs, rmii_txd, rmii_tx_en, tx_er_seen} !== 12'h000)
      $display("FAIL reset_outputs got=%h expected 000",
               {mii_clk_en, mii_rxd, mii_rx_dv, mii_rx_er, mii_crs, rmii_txd, rmii_tx_en, tx_er_seen});
    else passed++;
    rst = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_tx_100();
    logic [3:0] nibs [4];
    logic [1:0] exp_d [8];
    nibs  = '{4'h5, 4'h5, 4'hD, 4'hA};
    exp_d = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b11, 2'b10, 2'b10};
    wait_strobe();
    for (int i = 0; i < 4; i++) begin
      mii_tx_en = 1'b1; mii_txd = nibs[i];
      step();
      total++;
      if (rmii_txd !== exp_d[2*i] || rmii_tx_en !== 1'b1)
        $display("FAIL tx100_lo[%0d] got=%b/%b expected %b/1", i, rmii_txd, rmii_tx_en, exp_d[2*i]);
      else passed++;
      step();
      total++;
      if (rmii_txd !== exp_d[2*i+1] || rmii_tx_en !== 1'b1 || mii_clk_en !== 1'b1)
        $display("FAIL tx100_hi[%0d] got=%b/%b strobe=%b expected %b/1 strobe=1",
                 i, rmii_txd, rmii_tx_en, mii_clk_en, exp_d[2*i+1]);
      else passed++;
    end
    mii_tx_en = 1'b0; mii_txd = 4'hF;
    step();
    total++;
    if (rmii_txd !== 2'b00 || rmii_tx_en !== 1'b0)
      $display("FAIL tx100_idle got=%b/%b expected 00/0", rmii_txd, rmii_tx_en);
    else passed++;
  endtask

  task automatic test_tx_er();
    wait_strobe();
    mii_tx_en = 1'b0; mii_tx_er = 1'b1;
    repeat (2) step();
    total++;
    if (tx_er_seen !== 1'b0) $display("FAIL tx_er_no_en got=%b expected 0", tx_er_seen);
    else passed++;
    wait_strobe();
    mii_tx_en = 1'b1; mii_txd = 4'h3;
    step();
    total++;
    if (tx_er_seen !== 1'b1 || rmii_txd !== 2'b11 || rmii_tx_en !== 1'b1)
      $display("FAIL tx_er_set got=%b txd=%b en=%b expected 1 11 1", tx_er_seen, rmii_txd, rmii_tx_en);
    else passed++;
    mii_tx_en = 1'b0; mii_tx_er = 1'b0; mii_txd = '0;
    repeat (6) step();
    total++;
    if (tx_er_seen !== 1'b1 || rmii_tx_en !== 1'b0)
      $display("FAIL tx_er_sticky got=%b en=%b expected 1 0", tx_er_seen, rmii_tx_en);
    else passed++;
  endtask

  task automatic test_rx_100();
    logic [3:0] exp_n [3];
    logic [3:0] got;
    exp_n = '{4'h5, 4'hD, 4'hA};
    load_basic_frame();
    drive_rx(1);
    total++;
    if (cap_nib.size() != 3) $display("FAIL rx100_count got=%0d expected 3", cap_nib.size());
    else passed++;
    for (int j = 0; j < 3; j++) begin
      got = (j < cap_nib.size()) ? cap_nib[j] : 4'hx;
      total++;
      if (got !== exp_n[j] || (j < cap_nib.size() && (cap_crs[j] !== 1'b1 || cap_er[j] !== 1'b0)))
        $display("FAIL rx100_nib[%0d] got=%h expected %h crs=1 er=0", j, got, exp_n[j]);
      else passed++;
    end
    total++;
    if (mii_rx_dv !== 1'b0 || mii_crs !== 1'b0)
      $display("FAIL rx100_end dv=%b crs=%b expected 0 0", mii_rx_dv, mii_crs);
    else passed++;
  endtask

  task automatic test_rx_toggle();
    logic [3:0] exp_n [3];
    logic       exp_c [3];
    logic [3:0] got;
    exp_n = '{4'h5, 4'h3, 4'h6};
    exp_c = '{1'b1, 1'b0, 1'b0};
    st_n = 0;
    add(2'b00, 1, 0); add(2'b01, 1, 0); add(2'b01, 1, 0);
    add(2'b11, 0, 0); add(2'b00, 1, 0);
    add(2'b10, 0, 0); add(2'b01, 1, 0);
    add(2'b00, 0, 0); add(2'b00, 0, 0);
    drive_rx(1);
    total++;
    if (cap_nib.size() != 3) $display("FAIL toggle_count got=%0d expected 3", cap_nib.size());
    else passed++;
    for (int j = 0; j < 3; j++) begin
      got = (j < cap_nib.size()) ? cap_nib[j] : 4'hx;
      total++;
      if (got !== exp_n[j] || (j < cap_crs.size() && cap_crs[j] !== exp_c[j]))
        $display("FAIL toggle_nib[%0d] got=%h crs=%b expected %h crs=%b",
                 j, got, (j < cap_crs.size()) ? cap_crs[j] : 1'bx, exp_n[j], exp_c[j]);
      else passed++;
    end
    total++;
    if (mii_rx_dv !== 1'b0) $display("FAIL toggle_end dv=%b expected 0", mii_rx_dv);
    else passed++;
  endtask

  task automatic test_rx_err();
    st_n = 0;
    add(2'b00, 1, 0); add(2'b00, 1, 1); add(2'b01, 1, 0); add(2'b01, 1, 0);
    add(2'b11, 1, 0); add(2'b10, 1, 1);
    drive_rx(1);
    total++;
    if (cap_nib.size() != 2 || cap_nib[0] !== 4'h5 || cap_nib[1] !== 4'hB)
      $display("FAIL rxerr_data count=%0d expected 2 nibbles 5,B", cap_nib.size());
    else passed++;
    total++;
    if (cap_er.size() != 2 || cap_er[0] !== 1'b0 || cap_er[1] !== 1'b1)
      $display("FAIL rxerr_flags count=%0d expected er 0,1", cap_er.size());
    else passed++;
  endtask

  task automatic test_false_carrier();
    int unsigned dv_hits = 0;
    logic prev;
    rmii_crs_dv = 1'b1; rmii_rx_er = 1'b1; rmii_rxd = 2'b10;
    step();
    rmii_rx_er = 1'b0; rmii_rxd = 2'b01;
    for (int i = 0; i < 7; i++) begin
      prev = mii_clk_en;
      step();
      if (prev && mii_rx_dv) dv_hits++;
    end
    total++;
    if (mii_rx_er !== 1'b1 || mii_rxd !== 4'hE || mii_rx_dv !== 1'b0 || dv_hits != 0)
      $display("FAIL false_carrier er=%b rxd=%h dv=%b dv_hits=%0d expected 1 E 0 0",
               mii_rx_er, mii_rxd, mii_rx_dv, dv_hits);
    else passed++;
    rmii_crs_dv = 1'b0; rmii_rxd = 2'b00;
    repeat (5) step();
    total++;
    if (mii_rx_er !== 1'b0 || mii_rx_dv !== 1'b0)
      $display("FAIL false_carrier_end er=%b dv=%b expected 0 0", mii_rx_er, mii_rx_dv);
    else passed++;
  endtask

  task automatic test_10m();
    int unsigned n;
    int unsigned bad;
    logic [3:0] exp_n [3];
    exp_n = '{4'h5, 4'hD, 4'hA};
    speed_100 = 1'b0;
    repeat (4) step();
    wait_strobe();
    step();
    n = 1;
    while (!mii_clk_en && n < 100) begin step(); n++; end
    total++;
    if (n != 20) $display("FAIL clk_en_period_10m got=%0d expected 20", n);
    else passed++;

    mii_tx_en = 1'b1; mii_txd = 4'hA;
    step();
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      if (rmii_txd !== 2'b10 || rmii_tx_en !== 1'b1) bad++;
      if (k == 19) mii_txd = 4'h6;
      step();
    end
    total++;
    if (bad != 0) $display("FAIL tx10_A bad_cycles=%0d expected 0", bad);
    else passed++;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      if (rmii_txd !== ((k < 10) ? 2'b10 : 2'b01)) bad++;
      if (k == 19) begin mii_tx_en = 1'b0; mii_txd = '0; end
      step();
    end
    total++;
    if (bad != 0) $display("FAIL tx10_6 bad_cycles=%0d expected 0", bad);
    else passed++;

    wait_strobe();
    load_basic_frame();
    drive_rx(10);
    total++;
    if (cap_nib.size() != 3 || cap_nib[0] !== exp_n[0] || cap_nib[1] !== exp_n[1] || cap_nib[2] !== exp_n[2])
      $display("FAIL rx10_frame count=%0d expected 3 nibbles 5,D,A", cap_nib.size());
    else passed++;
    speed_100 = 1'b1;
    repeat (6) step();
  endtask

  task automatic test_reset_mid_frame();
    logic [3:0] exp_n [3];
    exp_n = '{4'h5, 4'hD, 4'hA};
    mii_tx_en = 1'b1; mii_tx_er = 1'b1; mii_txd = 4'hF;
    load_basic_frame();
    add(2'b01, 1, 0); add(2'b01, 1, 0);
    for (int unsigned i = 0; i < st_n; i++) begin
      rmii_rxd = st_d[i]; rmii_crs_dv = st_c[i]; rmii_rx_er = st_e[i];
      step();
    end
    total++;
    if ({rmii_tx_en, tx_er_seen, mii_rx_dv, mii_crs} !== 4'b1111)
      $display("FAIL pre_reset_active got=%b expected 1111", {rmii_tx_en, tx_er_seen, mii_rx_dv, mii_crs});
    else passed++;
    #4 rst = 1'b1;
    #2;
    total++;
    if ({mii_clk_en, mii_rxd, mii_rx_dv, mii_rx_er, mii_crs, rmii_txd, rmii_tx_en, tx_er_seen} !== 12'h000)
      $display("FAIL async_reset got=%h expected 000",
               {mii_clk_en, mii_rxd, mii_rx_dv, mii_rx_er, mii_crs, rmii_txd, rmii_tx_en, tx_er_seen});
    else passed++;
    mii_tx_en = 1'b0; mii_tx_er = 1'b0; mii_txd = '0;
    rmii_rxd = '0; rmii_crs_dv = 1'b0; rmii_rx_er = 1'b0;
    step();
    rst = 1'b0;
    repeat (3) step();
    load_basic_frame();
    drive_rx(1);
    total++;
    if (cap_nib.size() != 3 || cap_nib[0] !== exp_n[0] || cap_nib[1] !== exp_n[1] || cap_nib[2] !== exp_n[2])
      $display("FAIL post_reset_frame count=%0d expected 3 nibbles 5,D,A", cap_nib.size());
    else passed++;
  endtask

  initial begin
    test_reset();
    test_tx_100();
    test_tx_er();
    test_rx_100();
    test_rx_toggle();
    test_rx_err();
    test_false_carrier();
    test_10m();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
